// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory port, redirect, decode handshake and status.
// master = sequencer, slave = memory/decode environment.
interface fetch_sequencer_if #(
  parameter int QDEPTH = 2
) ();
  localparam int CW = $clog2(QDEPTH) + 1;

  logic          en;
  logic [7:0]    imem_addr;
  logic [31:0]   imem_instr;
  logic          redirect_valid;
  logic [7:0]    redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [7:0]    inst_pc;
  logic [CW-1:0] q_count;
  logic          end_of_mem;
  logic [1:0]    dbg_state;

  modport master (
    input  en, imem_instr, redirect_valid, redirect_pc, inst_ready,
    output imem_addr, inst_valid, inst_data, inst_pc, q_count, end_of_mem, dbg_state
  );

  modport slave (
    output en, imem_instr, redirect_valid, redirect_pc, inst_ready,
    input  imem_addr, inst_valid, inst_data, inst_pc, q_count, end_of_mem, dbg_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, fills a small instruction queue
// one word per cycle, presents the head to decode, and halts after byte address 8'hFC.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         QDEPTH   = 2
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] LAST_PC = 8'hFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic          r_eom;
  logic [31:0]   r_qdata [QDEPTH];
  logic [7:0]    r_qpc   [QDEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_last;

  // Decode handshake: a transfer happens on any edge where inst_valid && inst_ready;
  // inst_valid only falls after a pop, a redirect or reset, and the head is held
  // stable while inst_valid && !inst_ready.
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.inst_ready;
  assign w_push  = (r_state == S_RUN) & bus.en & ((r_count < CW'(QDEPTH)) | w_pop);
  assign w_last  = (r_pc == LAST_PC);

  always_comb begin
    w_next = r_state;
    if (bus.redirect_valid) begin
      w_next = bus.en ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.en) w_next = S_RUN;
        S_RUN: begin
          if (!bus.en)               w_next = S_IDLE;
          else if (w_push && w_last) w_next = S_STOP;
        end
        S_STOP:  w_next = S_STOP;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Redirect wins over push and pop: the queue is emptied by resetting the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= {RESET_PC[7:2], 2'b00};
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_eom   <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc    <= {bus.redirect_pc[7:2], 2'b00};
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_eom   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
        if (w_last) r_eom <= 1'b1;
        else        r_pc  <= r_pc + 8'd4;
      end
      if (w_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.redirect_valid && w_push) begin
      r_qdata[r_tail] <= bus.imem_instr;
      r_qpc[r_tail]   <= r_pc;
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_data  = w_valid ? r_qdata[r_head] : 32'h0;
  assign bus.inst_pc    = w_valid ? r_qpc[r_head] : 8'h00;
  assign bus.q_count    = r_count;
  assign bus.end_of_mem = r_eom;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_sequencer;
  localparam int QD = 2;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
  } ent_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem [64];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer_if #(.QDEPTH(QD)) bus ();

  fetch_sequencer #(.RESET_PC(8'h00), .QDEPTH(QD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  // Reference model: a plain FIFO of {pc, word}; fetching is armed one edge after
  // en is seen high, stops for good once 8'hFC has been queued, until a redirect.
  ent_t       m_q[$];
  logic [7:0] m_pc    = 8'h00;
  bit         m_armed = 1'b0;
  bit         m_halt  = 1'b0;
  bit         m_eom   = 1'b0;
  bit         m_pop;
  bit         m_push;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_pc = 8'h00; m_armed = 1'b0; m_halt = 1'b0; m_eom = 1'b0;
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pc = {bus.redirect_pc[7:2], 2'b00};
      m_eom = 1'b0; m_halt = 1'b0; m_armed = bus.en;
    end else begin
      m_pop  = (m_q.size() != 0) && bus.inst_ready;
      m_push = m_armed && !m_halt && bus.en && ((m_q.size() < QD) || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back({m_pc, mem[m_pc[7:2]]});
        if (m_pc == 8'hFC) begin
          m_halt = 1'b1; m_eom = 1'b1;
        end else begin
          m_pc = m_pc + 8'd4;
        end
      end
      if (!m_halt) m_armed = bus.en;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("mdl_valid", 32'(bus.inst_valid), 32'(m_q.size() != 0));
      chk("mdl_data", bus.inst_data, (m_q.size() != 0) ? m_q[0].data : 32'h0);
      chk("mdl_pc", 32'(bus.inst_pc), (m_q.size() != 0) ? 32'(m_q[0].pc) : 32'h0);
      chk("mdl_count", 32'(bus.q_count), m_q.size());
      chk("mdl_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("mdl_eom", 32'(bus.end_of_mem), 32'(m_eom));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string name, input logic [7:0] pc, input logic [31:0] data,
                             input int count);
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'(count != 0));
    chk({name, "_pc"}, 32'(bus.inst_pc), 32'(pc));
    chk({name, "_data"}, bus.inst_data, data);
    chk({name, "_count"}, 32'(bus.q_count), 32'(count));
  endtask

  task automatic expect_reset_outputs(input string name);
    chk({name, "_addr"}, 32'(bus.imem_addr), 32'h0);
    expect_head(name, 8'h00, 32'h0, 0);
    chk({name, "_eom"}, 32'(bus.end_of_mem), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick(1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] seq_data [4];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h00007033;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00200113;
    mem[3]  = 32'h00308193;
    mem[9]  = 32'h404404b3;
    mem[18] = 32'h02b02823;
    for (int i = 0; i < 4; i++) seq_data[i] = mem[i];
    bus.en = 1'b0; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;

    #1 rst_n = 1'b0;
    #2 expect_reset_outputs("rst");
    chk("rst_state", 32'(bus.dbg_state), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Streaming with decode always ready: one instruction per cycle after 2 edges.
    @(negedge clk);
    bus.en = 1'b1; bus.inst_ready = 1'b1;
    tick(2);
    expect_head("stream0", 8'h00, 32'h00007033, 1);
    for (int k = 1; k < 4; k++) begin
      tick(1);
      expect_head($sformatf("stream%0d", k), 8'(k * 4), seq_data[k], 1);
    end

    // Backpressure from the start: queue fills to 2 and fetch stalls at 8'h08.
    do_reset();
    bus.en = 1'b1;
    tick(2);
    expect_head("bp_first", 8'h00, 32'h00007033, 1);
    tick(4);
    expect_head("bp_full", 8'h00, 32'h00007033, 2);
    chk("bp_addr", 32'(bus.imem_addr), 32'h08);

    @(negedge clk) bus.inst_ready = 1'b1;
    tick(1);
    expect_head("full_pushpop", 8'h04, 32'h00100093, 2);
    @(negedge clk) bus.inst_ready = 1'b0;

    // Redirect to an unaligned target while full.
    redirect_to(8'h27);
    tick(1);
    expect_head("redir_target", 8'h24, 32'h404404b3, 1);

    // Run into the end of memory.
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hF8;
    tick(1);
    expect_head("eom_flush", 8'h00, 32'h0, 0);
    chk("eom_flush_addr", 32'(bus.imem_addr), 32'hF8);
    @(negedge clk) bus.redirect_valid = 1'b0;
    tick(1);
    expect_head("eom_f8", 8'hF8, mem[62], 1);
    tick(1);
    chk("eom_set", 32'(bus.end_of_mem), 32'h1);
    chk("eom_count", 32'(bus.q_count), 32'h2);
    @(negedge clk) bus.en = 1'b0;
    tick(1);
    chk("eom_hold_addr", 32'(bus.imem_addr), 32'hFC);
    chk("eom_hold_count", 32'(bus.q_count), 32'h2);
    @(negedge clk) bus.inst_ready = 1'b1;
    tick(1);
    expect_head("eom_drain1", 8'hFC, mem[63], 1);
    tick(1);
    expect_head("eom_drained", 8'h00, 32'h0, 0);
    chk("eom_still", 32'(bus.end_of_mem), 32'h1);
    chk("eom_final_addr", 32'(bus.imem_addr), 32'hFC);

    @(negedge clk) bus.en = 1'b1;
    redirect_to(8'h48);
    chk("eom_cleared", 32'(bus.end_of_mem), 32'h0);
    tick(1);
    expect_head("redir48", 8'h48, 32'h02b02823, 1);

    // en low with one entry queued: entry stays, no new fetch, then it drains.
    @(negedge clk);
    bus.en = 1'b0; bus.inst_ready = 1'b0;
    tick(3);
    expect_head("en0_hold", 8'h48, 32'h02b02823, 1);
    chk("en0_addr", 32'(bus.imem_addr), 32'h4C);
    @(negedge clk) bus.inst_ready = 1'b1;
    tick(1);
    expect_head("en0_drain", 8'h00, 32'h0, 0);
    chk("en0_addr2", 32'(bus.imem_addr), 32'h4C);

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.en             = ($urandom_range(0, 9) != 0);
      bus.inst_ready     = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(8'hE0, 8'hFF));
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    bus.en = 1'b1; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
    tick(4);
    #3 rst_n = 1'b0;
    #1 expect_reset_outputs("async_rst");
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    expect_head("post_rst", 8'h00, 32'h00007033, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
